aes_ct_serializer: RTL and testbench

Downstream stage of `aes_encryptor_top`. Captures each 128-bit ciphertext block on the encryptor's one-cycle `valid` pulse and buffers it in a small block FIFO. Streams the buffered blocks out as bytes, most-significant byte first, over a valid/ready handshake to the byte-wide transmit path (UART/host link). Flags dropped blocks when the buffer is full.

---
 rtl/aes_ct_serializer.sv | 90 +++++++++
 tb/tb_aes_ct_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_serializer.sv
// Buffers 128-bit ciphertext blocks (DEPTH slots) and streams them as bytes, MSB first.
// Latency: byte 0 is presented the cycle after capture; 1 byte/cycle, no bubble between blocks.
// Backpressure: out_byte/out_last hold while out_ready=0; a full buffer drops blocks (sticky overflow). `AES_SER_LAST_EN enables out_last.
module aes_ct_serializer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] ct_in,
    input  logic         ct_valid,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overflow,
    input  logic         ovf_clr
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {S_EMPTY, S_STREAM} state_t;

    state_t          state, next_state;
    logic [127:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [3:0]      idx;
    logic [127:0]    head, shifted;
    logic            xfer, pop, push, drop;

    assign xfer = out_valid && out_ready;
    assign pop  = xfer && (idx == 4'd15);
    // A pop on the same edge frees the slot the incoming block needs.
    assign push = ct_valid && ((count < CW'(DEPTH)) || pop);
    assign drop = ct_valid && !push;

    always_comb begin
        count_nxt  = count;
        next_state = state;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (pop && !push)
            count_nxt = count - CW'(1);
        next_state = (count_nxt == '0) ? S_EMPTY : S_STREAM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_EMPTY;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            count <= count_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (xfer)
                idx <= idx + 4'd1;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Payload storage needs no reset: it is only visible while busy.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ct_in;
    end

    assign busy      = (state == S_STREAM);
    assign out_valid = busy;
    assign head      = mem[rd_ptr];
    assign shifted   = head << {idx, 3'b000};
    assign out_byte  = busy ? shifted[127:120] : 8'h00;

`ifdef AES_SER_LAST_EN
    assign out_last = busy && (idx == 4'd15);
`else
    assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed self-checking bench for aes_ct_serializer (DEPTH=2).
module tb_aes_ct_serializer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] ct_in;
    logic         ct_valid;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         overflow;
    logic         ovf_clr;

    int errs   = 0;
    int checks = 0;

    localparam logic [127:0] BLK_A = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] BLK_B = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] BLK_C = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] BLK_D = 128'h303132333435363738393A3B3C3D3E3F;

    logic [7:0] exp_a [16] = '{8'h69, 8'hC4, 8'hE0, 8'hD8, 8'h6A, 8'h7B, 8'h04, 8'h30,
                               8'hD8, 8'hCD, 8'hB7, 8'h80, 8'h70, 8'hB4, 8'hC5, 8'h5A};

    aes_ct_serializer #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ct_in     (ct_in),
        .ct_valid  (ct_valid),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic last_exp(input int k);
`ifdef AES_SER_LAST_EN
        return (k == 15);
`else
        return 1'b0;
`endif
    endfunction

    task automatic capture(input logic [127:0] blk);
        ct_in    = blk;
        ct_valid = 1'b1;
        @(negedge clk);
        ct_valid = 1'b0;
    endtask

    // Checks one full block leaving the port; toggle stalls every other cycle.
    task automatic drain(input logic [7:0] base, input bit use_a, input bit toggle, output int cyc);
        int k;
        logic [7:0] e;
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            e = use_a ? exp_a[k] : base + 8'(k);
            chk("out_valid", out_valid, 1);
            chk("out_byte", out_byte, e);
            chk("out_last", out_last, last_exp(k));
            if (out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        if (k < 16) chk("drain_timeout", k, 16);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_byte"}, out_byte, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        ct_in     = '0;
        ct_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_ovf", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single block, consumer always ready.
        capture(BLK_A);
        drain(8'h00, 1'b1, 1'b0, cyc);
        chk("single_cycles", cyc, 16);
        check_idle("single_end");

        // Same block with ready toggling 1/0.
        capture(BLK_A);
        drain(8'h00, 1'b1, 1'b1, cyc);
        chk("bp_cycles", cyc, 31);
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("bp_end");

        // Back-to-back: second block captured 3 cycles after the first.
        capture(BLK_B);
        for (int c = 0; c < 32; c++) begin
            ct_valid = (c == 2);
            ct_in    = BLK_C;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_byte", out_byte, (c < 16) ? 8'h10 + 8'(c) : 8'h20 + 8'(c - 16));
            @(negedge clk);
        end
        ct_valid = 1'b0;
        check_idle("b2b_end");

        // Overflow: third block dropped while stalled.
        out_ready = 1'b0;
        capture(BLK_B);
        capture(BLK_C);
        chk("ovf_before_drop", overflow, 0);
        capture(BLK_D);
        chk("ovf_set", overflow, 1);
        chk("ovf_busy", busy, 1);
        chk("ovf_hold_byte", out_byte, 8'h10);
        drain(8'h10, 1'b0, 1'b0, cyc);
        drain(8'h20, 1'b0, 1'b0, cyc);
        check_idle("ovf_drained");
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full buffer: write lands on the same edge as the byte-15 pop.
        out_ready = 1'b0;
        capture(BLK_B);
        capture(BLK_C);
        for (int k = 0; k < 16; k++) begin
            out_ready = 1'b1;
            ct_valid  = (k == 15);
            ct_in     = BLK_D;
            chk("full_pop_byte", out_byte, 8'h10 + 8'(k));
            @(negedge clk);
        end
        ct_valid = 1'b0;
        chk("full_pop_no_ovf", overflow, 0);
        drain(8'h20, 1'b0, 1'b0, cyc);
        drain(8'h30, 1'b0, 1'b0, cyc);
        check_idle("full_pop_end");

        // Asynchronous reset after byte 5 has transferred.
        capture(BLK_A);
        for (int k = 0; k < 6; k++) begin
            chk("mid_byte", out_byte, exp_a[k]);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        chk("mid_rst_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_valid", out_valid, 0);
            @(negedge clk);
        end
        capture(BLK_D);
        drain(8'h30, 1'b0, 1'b0, cyc);
        check_idle("post_rst_end");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
